// File: rtl/mem_bus_arbiter.sv
// Arbitrates one memory port between instruction fetch (if_*) and load/store (d_*), one transaction at a time.
// Define ARB_RR_EN for round-robin arbitration; otherwise data has priority with a fetch starvation guard.
module mem_bus_arbiter #(
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 19,
  parameter int MEM_LAT      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_t             state_reg;
  logic               sel_d_reg;
  logic               we_reg;
  logic [LAT_W-1:0]   lat_cnt_reg;
  logic               any_req;
  logic               grant_d;

  assign any_req = if_req | d_req;

`ifdef ARB_RR_EN
  // High when data should win the next tie; data is favoured first out of reset.
  logic rr_prio_d_reg;

  assign grant_d = d_req & (~if_req | rr_prio_d_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_prio_d_reg <= 1'b1;
    end else if (state_reg == IDLE && any_req) begin
      rr_prio_d_reg <= ~grant_d;
    end
  end
`else
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic [STARVE_W-1:0] starve_cnt_reg;
  logic                starved;

  assign starved = (starve_cnt_reg >= STARVE_W'(STARVE_LIMIT));
  assign grant_d = d_req & ~(if_req & starved);

  // Counts data wins taken while fetch was waiting; saturates at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_reg <= '0;
    end else if (state_reg == IDLE) begin
      if (!if_req || !grant_d) begin
        starve_cnt_reg <= '0;
      end else if (!starved) begin
        starve_cnt_reg <= starve_cnt_reg + STARVE_W'(1);
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      sel_d_reg   <= 1'b0;
      we_reg      <= 1'b0;
      lat_cnt_reg <= '0;
      if_gnt      <= 1'b0;
      if_rvalid   <= 1'b0;
      if_rdata    <= '0;
      d_gnt       <= 1'b0;
      d_done      <= 1'b0;
      d_rdata     <= '0;
      mem_address <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_wdata   <= '0;
      busy        <= 1'b0;
    end else begin
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_done    <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            state_reg   <= ISSUE;
            busy        <= 1'b1;
            sel_d_reg   <= grant_d;
            we_reg      <= grant_d & d_we;
            if_gnt      <= ~grant_d;
            d_gnt       <= grant_d;
            mem_address <= grant_d ? d_addr : if_addr;
            mem_read    <= ~(grant_d & d_we);
            mem_write   <= grant_d & d_we;
            mem_wdata   <= (grant_d & d_we) ? d_wdata : '0;
          end
        end
        ISSUE: begin
          mem_address <= '0;
          mem_read    <= 1'b0;
          mem_write   <= 1'b0;
          mem_wdata   <= '0;
          lat_cnt_reg <= LAT_W'(MEM_LAT - 1);
          if (we_reg) begin
            state_reg <= RESP;
            d_done    <= 1'b1;
          end else begin
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          // Read data is valid exactly MEM_LAT cycles after the strobe cycle.
          if (lat_cnt_reg == '0) begin
            state_reg <= RESP;
            if (sel_d_reg) begin
              d_rdata <= mem_rdata;
              d_done  <= 1'b1;
            end else begin
              if_rdata  <= mem_rdata;
              if_rvalid <= 1'b1;
            end
          end else begin
            lat_cnt_reg <= lat_cnt_reg - LAT_W'(1);
          end
        end
        RESP: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: one MEM_LAT=1 instance for the main scenarios, one MEM_LAT=3 instance for reset-in-WAIT.
module tb_mem_bus_arbiter;

  localparam logic [18:0] GARBAGE = 19'h2AAAA;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance with MEM_LAT=1
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [18:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic        if_gnt, if_rvalid, d_gnt, d_done, mem_read, mem_write, busy;
  logic [18:0] if_rdata, d_rdata, mem_address, mem_wdata, mem_rdata;

  // Instance with MEM_LAT=3
  logic        rst_n3 = 1'b0;
  logic        if_req3 = 1'b0;
  logic [18:0] if_addr3 = '0;
  logic        if_gnt3, if_rvalid3, d_gnt3, d_done3, mem_read3, mem_write3, busy3;
  logic [18:0] if_rdata3, d_rdata3, mem_address3, mem_wdata3, mem_rdata3;

  int n_checks = 0;
  int n_fail   = 0;

  mem_bus_arbiter #(.ADDR_W(19), .DATA_W(19), .MEM_LAT(1), .STARVE_LIMIT(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_bus_arbiter #(.ADDR_W(19), .DATA_W(19), .MEM_LAT(3), .STARVE_LIMIT(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n3),
    .if_req(if_req3), .if_addr(if_addr3), .if_gnt(if_gnt3), .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
    .d_req(1'b0), .d_we(1'b0), .d_addr(19'h0), .d_wdata(19'h0),
    .d_gnt(d_gnt3), .d_done(d_done3), .d_rdata(d_rdata3),
    .mem_address(mem_address3), .mem_read(mem_read3), .mem_write(mem_write3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3), .busy(busy3)
  );

  // Memory contents; data is presented only in the single cycle strobe+latency.
  function automatic logic [18:0] mem_word(input logic [18:0] a);
    case (a)
      19'h00010: mem_word = 19'h12345;
      19'h00005: mem_word = 19'h0AAAA;
      19'h00006: mem_word = 19'h05555;
      default:   mem_word = a ^ 19'h3C3C3;
    endcase
  endfunction

  int          lat1 = 0, lat3 = 0;
  logic [18:0] maddr1 = '0, maddr3 = '0;

  always @(posedge clk) begin
    if (mem_read) begin
      lat1   <= 1;
      maddr1 <= mem_address;
    end else if (lat1 > 0) begin
      lat1 <= lat1 - 1;
    end
    if (mem_read3) begin
      lat3   <= 3;
      maddr3 <= mem_address3;
    end else if (lat3 > 0) begin
      lat3 <= lat3 - 1;
    end
  end

  assign mem_rdata  = (lat1 == 1) ? mem_word(maddr1) : GARBAGE;
  assign mem_rdata3 = (lat3 == 1) ? mem_word(maddr3) : GARBAGE;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    logic [9:0] order;
    logic [9:0] exp_order;
    int         ng;
    logic       seen;

    step(2);
    chk("rst_if_gnt", 32'(if_gnt), 32'd0);
    chk("rst_d_gnt", 32'(d_gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_address", 32'(mem_address), 32'd0);
    chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("rst_d_done", 32'(d_done), 32'd0);
    chk("rst_if_rdata", 32'(if_rdata), 32'd0);
    rst_n  = 1'b1;
    rst_n3 = 1'b1;
    step();

    // Fetch read, MEM_LAT=1
    if_req = 1'b1; if_addr = 19'h00010;
    step();
    chk("t1_if_gnt", 32'(if_gnt), 32'd1);
    chk("t1_mem_read", 32'(mem_read), 32'd1);
    chk("t1_mem_address", 32'(mem_address), 32'h10);
    chk("t1_mem_write", 32'(mem_write), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    if_req = 1'b0;
    step();
    chk("t1_if_gnt_off", 32'(if_gnt), 32'd0);
    chk("t1_mem_read_off", 32'(mem_read), 32'd0);
    chk("t1_if_rvalid_early", 32'(if_rvalid), 32'd0);
    step();
    chk("t1_if_rvalid", 32'(if_rvalid), 32'd1);
    chk("t1_if_rdata", 32'(if_rdata), 32'h12345);
    chk("t1_d_done", 32'(d_done), 32'd0);
    step();
    chk("t1_if_rvalid_off", 32'(if_rvalid), 32'd0);
    chk("t1_busy_off", 32'(busy), 32'd0);

    // Store
    d_req = 1'b1; d_we = 1'b1; d_addr = 19'h00020; d_wdata = 19'h7FFFF;
    step();
    chk("t2_d_gnt", 32'(d_gnt), 32'd1);
    chk("t2_mem_write", 32'(mem_write), 32'd1);
    chk("t2_mem_wdata", 32'(mem_wdata), 32'h7FFFF);
    chk("t2_mem_address", 32'(mem_address), 32'h20);
    chk("t2_mem_read", 32'(mem_read), 32'd0);
    d_req = 1'b0;
    step();
    chk("t2_d_done", 32'(d_done), 32'd1);
    chk("t2_mem_write_off", 32'(mem_write), 32'd0);
    chk("t2_mem_read_resp", 32'(mem_read), 32'd0);
    step();
    chk("t2_d_done_off", 32'(d_done), 32'd0);
    chk("t2_busy_off", 32'(busy), 32'd0);

    // Fresh reset so both arbitration modes start from the same priority state
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // Simultaneous load and fetch
    d_req = 1'b1; d_we = 1'b0; d_addr = 19'h00005;
    if_req = 1'b1; if_addr = 19'h00006;
    step();
    chk("t3_d_gnt", 32'(d_gnt), 32'd1);
    chk("t3_if_gnt", 32'(if_gnt), 32'd0);
    chk("t3_mem_address_d", 32'(mem_address), 32'h5);
    d_req = 1'b0;
    step(2);
    chk("t3_d_done", 32'(d_done), 32'd1);
    chk("t3_d_rdata", 32'(d_rdata), 32'h0AAAA);
    chk("t3_if_rvalid_none", 32'(if_rvalid), 32'd0);
    step(2);
    chk("t3_if_gnt2", 32'(if_gnt), 32'd1);
    chk("t3_mem_address_if", 32'(mem_address), 32'h6);
    if_req = 1'b0;
    step(2);
    chk("t3_if_rvalid", 32'(if_rvalid), 32'd1);
    chk("t3_if_rdata", 32'(if_rdata), 32'h05555);
    chk("t3_d_rdata_hold", 32'(d_rdata), 32'h0AAAA);
    chk("t3_d_done_none", 32'(d_done), 32'd0);
    step();

    // Both requesters held high: record grant order (1 = data)
`ifdef ARB_RR_EN
    exp_order = 10'b1010101010;
`else
    exp_order = 10'b1111011110;
`endif
    order = '0;
    ng = 0;
    d_we = 1'b1; d_addr = 19'h00030; d_wdata = 19'h00001; d_req = 1'b1;
    if_addr = 19'h00031; if_req = 1'b1;
    for (int cyc = 0; cyc < 200 && ng < 10; cyc++) begin
      step();
      if (d_gnt) begin
        order = {order[8:0], 1'b1};
        ng++;
      end
      if (if_gnt) begin
        order = {order[8:0], 1'b0};
        ng++;
      end
    end
    chk("t4_grant_count", 32'(ng), 32'd10);
    chk("t4_grant_order", 32'(order), 32'(exp_order));
    d_req = 1'b0; if_req = 1'b0;
    step(6);
    chk("t4_idle", 32'(busy), 32'd0);

    // MEM_LAT=3: reset while waiting for read data
    if_req3 = 1'b1; if_addr3 = 19'h00040;
    step();
    chk("t5_if_gnt", 32'(if_gnt3), 32'd1);
    if_req3 = 1'b0;
    step(2);
    chk("t5_busy_wait", 32'(busy3), 32'd1);
    chk("t5_mem_read_wait", 32'(mem_read3), 32'd0);
    rst_n3 = 1'b0;
    #1;
    chk("t5_busy_rst", 32'(busy3), 32'd0);
    chk("t5_if_rvalid_rst", 32'(if_rvalid3), 32'd0);
    chk("t5_if_rdata_rst", 32'(if_rdata3), 32'd0);
    step(2);
    rst_n3 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (if_rvalid3 || busy3) seen = 1'b1;
    end
    chk("t5_no_pulse_after_rst", 32'(seen), 32'd0);
    if_req3 = 1'b1; if_addr3 = 19'h00041;
    step();
    chk("t5_if_gnt2", 32'(if_gnt3), 32'd1);
    chk("t5_mem_address2", 32'(mem_address3), 32'h41);
    if_req3 = 1'b0;
    step(3);
    chk("t5_if_rvalid_early", 32'(if_rvalid3), 32'd0);
    step();
    chk("t5_if_rvalid", 32'(if_rvalid3), 32'd1);
    chk("t5_if_rdata", 32'(if_rdata3), 32'h3C382);
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
